// File: rtl/cache_mem_responder_if.sv
// Request/response bus between the data cache's memory port and cache_mem_responder.
interface cache_mem_responder_if;
   logic        rd_i;
   logic        wr_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        mem_ready_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        err_o;

   modport master (
      output rd_i, wr_i, addr_i, wdata_i,
      input  mem_ready_o, rdata_o, busy_o, err_o
   );

   modport slave (
      input  rd_i, wr_i, addr_i, wdata_i,
      output mem_ready_o, rdata_o, busy_o, err_o
   );
endinterface

// File: rtl/cache_mem_responder.sv
// Main-memory model for the data cache: fixed-latency single-word reads/write-backs.
// Optional CACHE_MEM_PERF_EN adds rd_count_o / wr_count_o completion counters.
module cache_mem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LATENCY = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   cache_mem_responder_if.slave  bus
`ifdef CACHE_MEM_PERF_EN
   ,
   output logic [31:0]           rd_count_o,
   output logic [31:0]           wr_count_o
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] req_idx;
   logic [31:0]       req_wdata;
   logic              req_wr;
   logic              req_err;
   logic              req_oor;

   logic [31:0]       ram [DEPTH];

   logic              acc_req;
   logic              acc_wr;
   logic              acc_err;
   logic              acc_oor;
   logic [ADDR_W-1:0] acc_idx;
   logic              go_resp;
   logic              rsp_wr;
   logic              rsp_err;
   logic              rsp_oor;
   logic [ADDR_W-1:0] rsp_idx;

   always_comb begin
      acc_req = bus.rd_i | bus.wr_i;
      acc_wr  = bus.wr_i;
      acc_idx = bus.addr_i[ADDR_W+1:2];
      acc_oor = |bus.addr_i[31:ADDR_W+2];
      acc_err = (bus.rd_i & bus.wr_i) | (|bus.addr_i[1:0]) | acc_oor;
      // LATENCY=1 jumps IDLE->RESP, so the response must come from the live request
      go_resp = ((state == IDLE) && acc_req && (LATENCY == 1)) ||
                ((state == WAIT) && (cnt == 4'd1));
      rsp_wr  = (state == IDLE) ? acc_wr  : req_wr;
      rsp_err = (state == IDLE) ? acc_err : req_err;
      rsp_oor = (state == IDLE) ? acc_oor : req_oor;
      rsp_idx = (state == IDLE) ? acc_idx : req_idx;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         cnt             <= '0;
         req_idx         <= '0;
         req_wdata       <= '0;
         req_wr          <= 1'b0;
         req_err         <= 1'b0;
         req_oor         <= 1'b0;
         bus.mem_ready_o <= 1'b0;
         bus.rdata_o     <= '0;
         bus.busy_o      <= 1'b0;
         bus.err_o       <= 1'b0;
      end else begin
         bus.mem_ready_o <= 1'b0;
         bus.err_o       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (acc_req) begin
                  req_idx    <= acc_idx;
                  req_wdata  <= bus.wdata_i;
                  req_wr     <= acc_wr;
                  req_err    <= acc_err;
                  req_oor    <= acc_oor;
                  cnt        <= 4'(LATENCY - 1);
                  bus.busy_o <= 1'b1;
                  state      <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               bus.busy_o <= 1'b0;
               state      <= DONE;
            end
            DONE: state <= IDLE;
         endcase
         if (go_resp) begin
            bus.mem_ready_o <= 1'b1;
            bus.err_o       <= rsp_err;
            if (!rsp_wr) bus.rdata_o <= rsp_oor ? '0 : ram[rsp_idx];
         end
      end
   end

   // Backing store is never cleared; the write commits at the end of the RESP cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i && (state == RESP) && req_wr && !req_oor)
         ram[req_idx] <= req_wdata;
   end

`ifdef CACHE_MEM_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_count_o <= '0;
         wr_count_o <= '0;
      end else if (state == RESP) begin
         if (req_wr) wr_count_o <= wr_count_o + 32'd1;
         else        rd_count_o <= rd_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder against a timeline/array model of the memory.
module tb_cache_mem_responder;
   localparam int L = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   cache_mem_responder_if bus ();
`ifdef CACHE_MEM_PERF_EN
   logic [31:0] rd_count, wr_count;
`endif

   cache_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(L)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus)
`ifdef CACHE_MEM_PERF_EN
      ,
      .rd_count_o(rd_count),
      .wr_count_o(wr_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int free_at  = 0;
   bit chk_en   = 0;

   // model: one transaction in flight, accepted at edge cur_a, answered after edge cur_a+L-1
   bit          cur_valid = 0;
   int          cur_a;
   bit          cur_wr, cur_err, cur_oor;
   logic [7:0]  cur_idx;
   logic [31:0] cur_wdata;
   logic [31:0] model_mem [256];
   logic [31:0] exp_rdata = '0;
   int          m_rd = 0, m_wr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      bit exp_ready, exp_busy;
      cyc++;
      #1;
      if (chk_en) begin
         exp_ready = cur_valid && (cyc == cur_a + L - 1);
         exp_busy  = cur_valid && (cyc >= cur_a) && (cyc <= cur_a + L - 1);
`ifdef CACHE_MEM_PERF_EN
         check("rd_count", rd_count, 32'(m_rd));
         check("wr_count", wr_count, 32'(m_wr));
`endif
         if (exp_ready) begin
            if (cur_wr) begin
               if (!cur_oor) model_mem[cur_idx] = cur_wdata;
               m_wr++;
            end else begin
               exp_rdata = cur_oor ? 32'h0 : model_mem[cur_idx];
               m_rd++;
            end
         end
         check("mem_ready", 32'(bus.mem_ready_o), 32'(exp_ready));
         check("busy", 32'(bus.busy_o), 32'(exp_busy));
         check("err", 32'(bus.err_o), 32'(exp_ready && cur_err));
         check("rdata", bus.rdata_o, exp_rdata);
      end
   end

   // Raise a request; returns at the negedge of the mem_ready cycle (or the DONE cycle if hold).
   task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
      int a;
      @(negedge clk);
      bus.rd_i = rd; bus.wr_i = wr; bus.addr_i = addr; bus.wdata_i = wdata;
      a = (cyc + 1 > free_at) ? cyc + 1 : free_at;
      cur_a = a; cur_wr = wr; cur_idx = addr[9:2]; cur_oor = |addr[31:10];
      cur_err = (rd && wr) || (addr[1:0] != 2'b00) || cur_oor;
      cur_wdata = wdata; cur_valid = 1;
      free_at = a + L + 2;
      while (cyc < a + L - 1) @(negedge clk);
      if (hold) @(negedge clk);
      bus.rd_i = 1'b0; bus.wr_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.rd_i = 1'b0; bus.wr_i = 1'b0;
      cur_valid = 0; exp_rdata = '0; m_rd = 0; m_wr = 0;
      @(negedge clk);
      rst = 1'b0; free_at = 0;
   endtask

   task automatic summary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      logic [31:0] addr;
      bus.rd_i = 1'b0; bus.wr_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(bus.mem_ready_o), 32'd0);
      check("reset_busy", 32'(bus.busy_o), 32'd0);
      check("reset_err", 32'(bus.err_o), 32'd0);
      check("reset_rdata", bus.rdata_o, 32'h0);
      rst = 1'b0;
      chk_en = 1;

      for (int i = 0; i < 32; i++) do_txn(0, 1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 0);

      // write then read 0x40
      do_txn(0, 1, 32'h40, 32'hDEADBEEF, 0);
      check("wr40_ready", 32'(bus.mem_ready_o), 32'd1);
      check("wr40_err", 32'(bus.err_o), 32'd0);
      do_txn(1, 0, 32'h40, 32'h0, 0);
      check("rd40_ready", 32'(bus.mem_ready_o), 32'd1);
      check("rd40_rdata", bus.rdata_o, 32'hDEADBEEF);

      // request held through DONE must not restart
      do_txn(1, 0, 32'h40, 32'h0, 1);
      check("done_busy", 32'(bus.busy_o), 32'd0);
      check("done_ready", 32'(bus.mem_ready_o), 32'd0);
      @(negedge clk);
      check("after_done_busy", 32'(bus.busy_o), 32'd0);

      // rd and wr together: write wins, flagged
      do_txn(1, 1, 32'h10, 32'h12345678, 0);
      check("both_err", 32'(bus.err_o), 32'd1);
      check("both_rdata_kept", bus.rdata_o, 32'hDEADBEEF);
      do_txn(1, 0, 32'h10, 32'h0, 0);
      check("both_readback", bus.rdata_o, 32'h12345678);

      // out of range
      do_txn(0, 1, 32'h400, 32'hAAAA5555, 0);
      check("oor_wr_err", 32'(bus.err_o), 32'd1);
      do_txn(1, 0, 32'h400, 32'h0, 0);
      check("oor_rd_err", 32'(bus.err_o), 32'd1);
      check("oor_rd_rdata", bus.rdata_o, 32'h0);
      do_txn(1, 0, 32'h0, 32'h0, 0);
      check("ram0_intact", bus.rdata_o, 32'hC0DE0000);

      // misaligned read is aligned down and flagged
      do_txn(1, 0, 32'h43, 32'h0, 0);
      check("misal_err", 32'(bus.err_o), 32'd1);
      check("misal_rdata", bus.rdata_o, 32'hDEADBEEF);

      // reset in the first WAIT cycle of a write
      @(negedge clk);
      bus.wr_i = 1'b1; bus.addr_i = 32'h20; bus.wdata_i = 32'hBADBAD00;
      a = (cyc + 1 > free_at) ? cyc + 1 : free_at;
      cur_a = a; cur_wr = 1; cur_idx = 8'h08; cur_oor = 0; cur_err = 0;
      cur_wdata = 32'hBADBAD00; cur_valid = 1;
      while (cyc < a) @(negedge clk);
      check("midrst_busy", 32'(bus.busy_o), 32'd1);
      rst = 1'b1; bus.wr_i = 1'b0;
      cur_valid = 0; exp_rdata = '0; m_rd = 0; m_wr = 0;
      @(negedge clk);
      rst = 1'b0; free_at = 0;
      check("midrst_ready", 32'(bus.mem_ready_o), 32'd0);
      do_txn(1, 0, 32'h20, 32'h0, 0);
      check("midrst_readback", bus.rdata_o, 32'hC0DE0008);

      // back-to-back write-back then refill
      do_txn(0, 1, 32'h44, 32'h55AA33CC, 0);
      do_txn(1, 0, 32'h44, 32'h0, 0);
      check("b2b_rdata", bus.rdata_o, 32'h55AA33CC);

      for (int n = 0; n < 300; n++) begin
         int op;
         addr = 32'($urandom_range(0, 31)) << 2;
         if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) addr[31:10] = 22'($urandom_range(1, 32'h3FFFFF));
         op = $urandom_range(0, 9);
         do_txn(op == 0 || op < 5, op == 0 || op >= 5, addr, $urandom(), 1'($urandom_range(0, 1)));
      end

`ifdef CACHE_MEM_PERF_EN
      do_reset();
      do_txn(0, 1, 32'h8, 32'h1, 0);
      do_txn(0, 1, 32'hC, 32'h2, 0);
      do_txn(1, 0, 32'h8, 32'h0, 0);
      do_txn(1, 0, 32'hC, 32'h0, 0);
      do_txn(1, 0, 32'h8, 32'h0, 0);
      @(negedge clk);
      check("perf_rd3", rd_count, 32'd3);
      check("perf_wr2", wr_count, 32'd2);
      do_reset();
      check("perf_rd_clr", rd_count, 32'd0);
      check("perf_wr_clr", wr_count, 32'd0);
`endif

      repeat (8) @(negedge clk);
      summary();
      $finish;
   end
endmodule
